adrv9001_tx_framer: RTL and testbench

Transmit-side SSI framer for the ADRV9001/2 LVDS interface, the counterpart of the receive channel. It accepts 32-bit IQ samples on an AXI-stream slave and produces per-cycle 8-bit I, Q and strobe words for the downstream OSERDES instances. It also runs the pin-mode enable sequencer that drives the ADRV9001 transmit enable pin and gates SSI data with programmable enable and disable delays. It runs entirely in the divided SSI clock domain (dclk/4); control inputs arrive already synchronised by `cdc` instances in the parent.

---
 rtl/adrv9001_tx_pkg.sv | 19 +
 rtl/adrv9001_tx_enable_ctrl.sv | 105 ++++++++++
 rtl/adrv9001_tx_framer.sv | 137 +++++++++++++
 tb/tb_adrv9001_tx_framer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_tx_pkg.sv
// adrv9001_tx_pkg
//   Shared types and constants for the ADRV9001 transmit SSI framer:
//   enable-sequencer state enum, strobe words, byte/sample widths.
package adrv9001_tx_pkg;

  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 16;

  localparam logic [BYTE_W-1:0] STROBE_SHORT = 8'h80;
  localparam logic [BYTE_W-1:0] STROBE_LONG  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_EN = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/adrv9001_tx_enable_ctrl.sv
// adrv9001_tx_enable_ctrl
//   Pin-mode enable sequencer. Drives the ADRV9001 TX enable pin and the
//   SSI-active flag, with programmable enable/disable delays in samples.
//   All state changes happen only on sample boundaries (i_boundary), so a
//   sample that started on the MSB cycle is always completed.
//   Ports:
//     i_clk, i_rstn          clock, async active-low reset
//     i_boundary             high on the LSB (second) cycle of each sample
//     i_enable, i_enable_mode  request and mode (0 = SPI, 1 = pin)
//     i_enable_delay, i_disable_delay  delay counts, sampled at load only
//     o_adrv9001_enable      TX enable pin
//     o_ssi_active           SSI accepting samples (ACTIVE or DRAIN)
//     o_cnt                  delay counter (only with ADRV9001_TX_FRAMER_DBG_EN)
module adrv9001_tx_enable_ctrl
  import adrv9001_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_boundary,
  input  logic        i_enable,
  input  logic        i_enable_mode,
  input  logic [15:0] i_enable_delay,
  input  logic [15:0] i_disable_delay,
`ifdef ADRV9001_TX_FRAMER_DBG_EN
  output logic [15:0] o_cnt,
`endif
  output logic        o_adrv9001_enable,
  output logic        o_ssi_active
);

  tx_state_e   r_state;
  logic [15:0] r_cnt;
  logic        r_adrv_en;
  logic        r_ssi_active;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_adrv_en    <= 1'b0;
      r_ssi_active <= 1'b0;
    end else if (i_boundary) begin
      if (!i_enable_mode) begin
        // SPI mode: the radio is enabled over SPI, SSI always streams.
        r_state      <= ST_ACTIVE;
        r_adrv_en    <= 1'b0;
        r_ssi_active <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ssi_active <= 1'b0;
            r_adrv_en    <= i_enable;
            if (i_enable) begin
              r_state <= ST_WAIT_EN;
              r_cnt   <= i_enable_delay;
            end
          end
          ST_WAIT_EN: begin
            if (!i_enable) begin
              r_state   <= ST_IDLE;
              r_adrv_en <= 1'b0;
            end else if (r_cnt == 16'd0) begin
              r_state      <= ST_ACTIVE;
              r_ssi_active <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          ST_ACTIVE: begin
            // Entered from SPI mode the pin was low; raise it now.
            r_adrv_en    <= 1'b1;
            r_ssi_active <= 1'b1;
            if (!i_enable) begin
              r_state <= ST_DRAIN;
              r_cnt   <= i_disable_delay;
            end
          end
          ST_DRAIN: begin
            if (i_enable) begin
              r_state <= ST_ACTIVE;
            end else if (r_cnt == 16'd0) begin
              r_state      <= ST_IDLE;
              r_adrv_en    <= 1'b0;
              r_ssi_active <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_adrv_en    <= 1'b0;
            r_ssi_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_adrv9001_enable = r_adrv_en;
  assign o_ssi_active      = r_ssi_active;
`ifdef ADRV9001_TX_FRAMER_DBG_EN
  assign o_cnt             = r_cnt;
`endif

endmodule

// File: rtl/adrv9001_tx_framer.sv
// adrv9001_tx_framer
//   Transmit SSI framer for the ADRV9001 LVDS interface, in the divided SSI
//   clock domain. Each 32-bit {I,Q} sample from the AXI-stream slave is sent
//   over two cycles: MSB bytes on phase 0, LSB bytes on phase 1. Strobe runs
//   continuously. Underflow sends IDLE_DATA without stalling.
//   Optional macro ADRV9001_TX_FRAMER_DBG_EN builds a saturating underflow
//   counter; o_dbg = {underflow_cnt, delay_cnt}. Otherwise o_dbg = 0.
//   Ports:
//     i_clk, i_rstn                 clock, async active-low reset
//     i_enable, i_enable_mode       TX enable request, mode (0 SPI / 1 pin)
//     i_enable_delay, i_disable_delay  sequencer delays in samples
//     o_adrv9001_enable             ADRV9001 TX enable pin
//     i_s_axis_tdata/tvalid, o_s_axis_tready  sample stream
//     o_i_data, o_q_data, o_strobe  serdes words, bit 7 first
//     o_ssi_active                  sequencer in ACTIVE or DRAIN
//     o_dbg                         debug word
module adrv9001_tx_framer
  import adrv9001_tx_pkg::*;
#(
  parameter bit          LONG_STROBE = 1'b0,
  parameter logic [31:0] IDLE_DATA   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic        i_enable_mode,
  input  logic [15:0] i_enable_delay,
  input  logic [15:0] i_disable_delay,
  output logic        o_adrv9001_enable,
  input  logic [31:0] i_s_axis_tdata,
  input  logic        i_s_axis_tvalid,
  output logic        o_s_axis_tready,
  output logic [7:0]  o_i_data,
  output logic [7:0]  o_q_data,
  output logic [7:0]  o_strobe,
  output logic        o_ssi_active,
  output logic [31:0] o_dbg
);

  localparam logic [BYTE_W-1:0] STROBE_WORD = LONG_STROBE ? STROBE_LONG : STROBE_SHORT;

  logic              r_phase;
  logic [BYTE_W-1:0] r_i_data, r_q_data, r_strobe;
  logic [BYTE_W-1:0] r_i_lsb, r_q_lsb;
  logic              w_ssi_active;
  logic              w_tready;
  logic [31:0]       w_smp;
  logic [SAMPLE_W-1:0] w_i, w_q;

`ifdef ADRV9001_TX_FRAMER_DBG_EN
  logic [15:0] w_cnt;
`endif

  adrv9001_tx_enable_ctrl u_enable_ctrl (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_boundary        (r_phase),
    .i_enable          (i_enable),
    .i_enable_mode     (i_enable_mode),
    .i_enable_delay    (i_enable_delay),
    .i_disable_delay   (i_disable_delay),
`ifdef ADRV9001_TX_FRAMER_DBG_EN
    .o_cnt             (w_cnt),
`endif
    .o_adrv9001_enable (o_adrv9001_enable),
    .o_ssi_active      (w_ssi_active)
  );

  // Ready depends on registers only, never on tvalid.
  assign w_tready = w_ssi_active & ~r_phase;
  assign w_smp    = (w_tready & i_s_axis_tvalid) ? i_s_axis_tdata : IDLE_DATA;
  assign w_i      = w_smp[2*SAMPLE_W-1:SAMPLE_W];
  assign w_q      = w_smp[SAMPLE_W-1:0];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_phase  <= 1'b0;
      r_i_data <= '0;
      r_q_data <= '0;
      r_strobe <= '0;
      r_i_lsb  <= '0;
      r_q_lsb  <= '0;
    end else begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_i_data <= w_i[SAMPLE_W-1:BYTE_W];
        r_q_data <= w_q[SAMPLE_W-1:BYTE_W];
        r_i_lsb  <= w_i[BYTE_W-1:0];
        r_q_lsb  <= w_q[BYTE_W-1:0];
        r_strobe <= STROBE_WORD;
      end else begin
        r_i_data <= r_i_lsb;
        r_q_data <= r_q_lsb;
        r_strobe <= '0;
      end
    end
  end

`ifdef ADRV9001_TX_FRAMER_DBG_EN
  logic        r_ssi_d;
  logic [15:0] r_uf_cnt;
  logic [31:0] r_dbg;
  logic [15:0] w_uf_base;

  // A 0->1 edge on ssi_active is exactly an entry to ACTIVE from IDLE or
  // WAIT_EN (DRAIN->ACTIVE keeps it high), so that edge clears the count.
  assign w_uf_base = (w_ssi_active & ~r_ssi_d) ? 16'd0 : r_uf_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ssi_d  <= 1'b0;
      r_uf_cnt <= '0;
      r_dbg    <= '0;
    end else begin
      r_ssi_d <= w_ssi_active;
      if (!r_phase) begin
        if (w_ssi_active & ~i_s_axis_tvalid & (w_uf_base != 16'hFFFF))
          r_uf_cnt <= w_uf_base + 16'd1;
        else
          r_uf_cnt <= w_uf_base;
      end
      r_dbg <= {r_uf_cnt, w_cnt};
    end
  end

  assign o_dbg = r_dbg;
`else
  assign o_dbg = '0;
`endif

  assign o_s_axis_tready = w_tready;
  assign o_i_data        = r_i_data;
  assign o_q_data        = r_q_data;
  assign o_strobe        = r_strobe;
  assign o_ssi_active    = w_ssi_active;

endmodule

// File: tb/tb_adrv9001_tx_framer.sv
module tb_adrv9001_tx_framer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        enable_mode = 1'b0;
  logic [15:0] en_dly = '0;
  logic [15:0] dis_dly = '0;
  logic        adrv_en;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [7:0]  i_data, q_data, strobe;
  logic        ssi;
  logic [31:0] dbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit ph = 1'b0;

  always #5 clk = ~clk;

  adrv9001_tx_framer dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_enable          (enable),
    .i_enable_mode     (enable_mode),
    .i_enable_delay    (en_dly),
    .i_disable_delay   (dis_dly),
    .o_adrv9001_enable (adrv_en),
    .i_s_axis_tdata    (tdata),
    .i_s_axis_tvalid   (tvalid),
    .o_s_axis_tready   (tready),
    .o_i_data          (i_data),
    .o_q_data          (q_data),
    .o_strobe          (strobe),
    .o_ssi_active      (ssi),
    .o_dbg             (dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One clock: active edge, then park on the falling edge for drive/sample.
  task automatic tick();
    @(posedge clk);
    ph = ~ph;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    ph = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, acc;
    bit low_seen;

    // ---------------- reset state / SPI mode ----------------
    enable_mode = 1'b0;
    tvalid = 1'b1;
    tdata = 32'h1234_ABCD;
    @(negedge clk);
    check("rst_data", {i_data, q_data, strobe}, 32'h0);
    check("rst_ctl", {tready, adrv_en, ssi}, 32'h0);
    check("rst_dbg", dbg, 32'h0);
    do_reset();
    tick();  // phase 0, still IDLE: idle data
    check("spi_e1", {i_data, q_data, strobe, 7'd0, ssi}, {8'h00, 8'h00, 8'h80, 8'h00});
    tick();  // boundary -> ACTIVE
    check("spi_e2", {strobe, 5'd0, tready, adrv_en, ssi}, {8'h00, 8'b0000_0101});
    tick();
    check("spi_msb", {i_data, q_data, strobe, 7'd0, tready}, {8'h12, 8'hAB, 8'h80, 8'h00});
    tick();
    check("spi_lsb", {i_data, q_data, strobe, 7'd0, adrv_en}, {8'h34, 8'hCD, 8'h00, 8'h00});
    tdata = 32'hFEDC_0123;
    tick();
    check("spi2_msb", {i_data, q_data}, 32'h0000_FE01);
    tick();
    check("spi2_lsb", {i_data, q_data}, 32'h0000_DC23);

    // ---------------- underflow ----------------
    tvalid = 1'b0;
    tdata = 32'h5A5A_5A5A;
    check("uf_tready", {31'd0, tready}, 32'd1);
    for (int s = 0; s < 5; s++) begin
      tick();
      check("uf_msb", {i_data, q_data, strobe}, 32'h0000_0080);
      tick();
      check("uf_lsb", {i_data, q_data, strobe}, 32'h0000_0000);
    end
    tvalid = 1'b1;
    tdata = 32'h5A5A_A5A5;
    tick();
    check("uf_resume", {i_data, q_data, strobe}, 32'h005A_A580);
    tick();
`ifdef ADRV9001_TX_FRAMER_DBG_EN
    check("uf_dbg", dbg, 32'h0005_0000);
`else
    check("dbg_off", dbg, 32'h0);
`endif

    // ---------------- pin mode enable delay ----------------
    enable_mode = 1'b1;
    enable = 1'b0;
    en_dly = 16'd3;
    do_reset();
    tick();
    tick();
    check("pin_idle", {30'd0, adrv_en, ssi}, 32'd0);
    enable = 1'b1;
    tick();
    tick();  // boundary -> WAIT_EN
    check("pin_en_rise", {30'd0, adrv_en, tready}, 32'b10);
    en_dly = 16'd7;  // must be ignored mid-count
    n = 0;
    while (!tready && n < 20) begin
      tick();
      tick();
      n++;
    end
    check("en_lat", n, 32'd4);
    check("pin_active", {30'd0, adrv_en, ssi}, 32'b11);
    tdata = 32'hC0DE_BEEF;
    tick();
    check("pin_msb", {i_data, q_data}, 32'h0000_C0BE);
    tick();
    check("pin_lsb", {i_data, q_data}, 32'h0000_DEEF);

    // ---------------- pin mode disable delay ----------------
    dis_dly = 16'd2;
    enable = 1'b0;
    tick();
    tick();  // boundary -> DRAIN
    dis_dly = 16'd9;
    acc = 0;
    n = 0;
    while (adrv_en && n < 20) begin
      if (tready) acc++;
      tick();
      tick();
      n++;
    end
    check("drain_acc", acc, 32'd3);
    check("dis_lat", n, 32'd3);
    check("drain_fall", {30'd0, ssi, tready}, 32'd0);

    // ---------------- re-raise in DRAIN ----------------
    en_dly = 16'd0;
    dis_dly = 16'd5;
    enable = 1'b1;
    tick(); tick();  // -> WAIT_EN
    tick(); tick();  // -> ACTIVE
    check("zero_dly", {30'd0, tready, adrv_en}, 32'b11);
    enable = 1'b0;
    tick(); tick();  // -> DRAIN
    tick(); tick();
    enable = 1'b1;
    low_seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (!adrv_en) low_seen = 1'b1;
    end
    check("reraise_low", {31'd0, low_seen}, 32'd0);
    check("reraise_act", {29'd0, adrv_en, ssi, tready}, 32'b111);

    // ---------------- drop in WAIT_EN ----------------
    dis_dly = 16'd0;
    enable = 1'b0;
    tick(); tick();  // -> DRAIN
    tick(); tick();  // -> IDLE
    check("to_idle", {30'd0, adrv_en, ssi}, 32'd0);
    en_dly = 16'd10;
    enable = 1'b1;
    tick(); tick();  // -> WAIT_EN
    check("wait_en", {30'd0, adrv_en, ssi}, 32'b10);
    tick(); tick();
    enable = 1'b0;
    tick(); tick();  // -> IDLE
    check("wait_drop", {29'd0, adrv_en, ssi, tready}, 32'd0);

    // ---------------- reset on a phase-1 cycle ----------------
    enable_mode = 1'b0;
    tdata = 32'h9876_5432;
    tick(); tick();  // -> ACTIVE
    tick();          // MSB loaded, now in the LSB cycle
    check("pre_rst", {i_data, q_data, strobe}, 32'h0098_5480);
    rstn = 1'b0;
    #1;
    check("arst_data", {i_data, q_data, strobe}, 32'h0);
    check("arst_ctl", {29'd0, tready, adrv_en, ssi}, 32'h0);
    check("arst_dbg", dbg, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    ph = 1'b0;
    tick();
    check("post_e1", {i_data, strobe, 15'd0, ssi}, {8'h00, 8'h80, 16'h0000});
    tick();
    check("post_e2", {strobe, 7'd0, ssi}, 32'h0000_0001);
    tick();
    check("post_msb", {i_data, q_data, strobe}, 32'h0098_5480);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
